// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor producing diff = a - b (mod 2^WIDTH),
//   one full-subtractor bit per clock, LSB first, with a start/done handshake.
//
// Ports
//   clk     single clock, rising edge
//   rst     synchronous, active-high reset
//   start   request; accepted in IDLE or DONE
//   a, b    minuend / subtrahend, captured on the accepting edge
//   busy    high while bits are being processed
//   done    one-cycle pulse when diff/borrow have just been updated
//   diff    registered result a - b mod 2^WIDTH
//   borrow  registered final borrow, 1 iff a < b (unsigned)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    count;
  logic             br_ff;

  // Full-subtractor cell on the current LSBs.
  logic x, y, d, br_next, last_bit;

  assign x        = a_sr[0];
  assign y        = b_sr[0];
  assign d        = x ^ y ^ br_ff;
  assign br_next  = (~x & y) | (~(x ^ y) & br_ff);
  assign last_bit = (count == CW'(WIDTH - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. DONE accepts a new start directly (back-to-back).
  // NOTE: default assignment first so no path leaves state_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath. Every register here is a handful of flops, so all of them are
  // cleared on reset, which also guarantees an aborted operation leaves no
  // trace in diff/borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      count  <= '0;
      br_ff  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            count <= '0;
            br_ff <= 1'b0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          // New bit enters at the MSB; after WIDTH shifts bit 0 is at the LSB.
          res_sr <= {d, res_sr[WIDTH-1:1]};
          br_ff  <= br_next;
          count  <= count + 1'b1;
          if (last_bit) begin
            diff   <= {d, res_sr[WIDTH-1:1]};
            borrow <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
